queue_seq_ctrl: RTL and testbench
=================================

QUEUE_SEQ_CTRL -- requirements
Module: queue_seq_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, 1024, circular queue depth in samples; must be a power of 2 and at least 4.
REQ-002 SHALL have parameter TAPS, 1021, number of read addresses per sequence; must satisfy 1 <= TAPS < DEPTH.
REQ-003 SHALL have parameter DECIM, 2, write decimation factor; legal values are 1 and 2.
REQ-004 SHALL have localparam ADDR_W = clog2(DEPTH).
REQ-005 SHALL have port clk  input  1  sole clock; all logic on the rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port valid  input  1  codec sample strobe (level).
REQ-008 SHALL have port wrt_smpl  output  1  one-cycle queue write strobe.
REQ-009 SHALL have port wr_addr  output  ADDR_W  queue write address; valid while wrt_smpl=1.
REQ-010 SHALL have port rd_addr  output  ADDR_W  queue read address; valid while sequencing=1.
REQ-011 SHALL have port sequencing  output  1  high during the TAPS-cycle FIR read burst.
REQ-012 SHALL have port AMP_ON  output  1  high once the queue has been filled.
REQ-013 SHALL have port overrun  output  1  sticky write-during-sequence flag; present only with SEQ_OVERRUN_EN.

Function
REQ-014 SHALL register valid as valid_d; an edge exists in cycle n when valid=1 and valid_d=0.
REQ-015 SHALL toggle phase on every edge, with reset value 0.
REQ-016 SHALL produce a qualified edge as follows: DECIM=1, every edge; DECIM=2, an edge seen with phase=1 (the 2nd, 4th, ... edge).
REQ-017 SHALL assert wrt_smpl for exactly one cycle at n+1 for each qualified edge at n.
REQ-018 SHALL drive wr_addr = new_ptr during wrt_smpl, then increment new_ptr modulo DEPTH.
REQ-019 SHALL count writes in fill_cnt, saturating at DEPTH; AMP_ON SHALL rise in the cycle after the write that brings fill_cnt to DEPTH and remain high until reset.
REQ-020 SHALL implement FSM states IDLE and SEQ with reset state IDLE.
REQ-021 SHALL transition IDLE->SEQ on a write with fill_cnt == DEPTH after that write.
REQ-022 SHALL, in SEQ, assert sequencing for exactly TAPS consecutive cycles starting at n+2.
REQ-023 SHALL drive rd_addr starting at the post-increment new_ptr (the oldest sample) and increment it by 1 modulo DEPTH each cycle.
REQ-024 SHALL return from SEQ to IDLE after the TAPS-th cycle, with sequencing low in the following cycle.
REQ-025 SHALL, on a write occurring while in SEQ, still perform the write and advance new_ptr, SHALL NOT restart or extend the current burst, and SHALL NOT queue an extra burst.
REQ-026 SHALL hold sequencing low, rd_addr at 0, and wrt_smpl low whenever no activity is defined by these requirements.
REQ-027 SHALL ignore an edge arriving while valid is held high continuously; only 0->1 transitions count.

Reset
REQ-028 SHALL, on rst=1 at a clock edge, clear wrt_smpl, wr_addr, rd_addr, sequencing, AMP_ON, overrun, new_ptr, fill_cnt and phase, and set the state to IDLE.
REQ-029 SHALL set valid_d to 1 on reset, so that valid held high through reset release produces no write.
REQ-030 SHALL, on reset asserted mid-SEQ, abort the burst: sequencing=0 in the next cycle, and no burst resumes after release.

Configuration
REQ-031 SHALL, with SEQ_OVERRUN_EN defined, implement port overrun, set it in the cycle after any write that occurs while in SEQ, and hold it until reset.
REQ-032 SHALL, without SEQ_OVERRUN_EN, omit the overrun port and its logic entirely; all other behaviour SHALL be identical.

Verification
REQ-033 SHALL cover reset: rst=1 for 2 cycles with valid=1 -> all outputs 0; after release with valid still 1 -> no wrt_smpl.
REQ-034 SHALL cover write strobing: DECIM=1, valid rises once and stays high 5 cycles -> exactly one wrt_smpl, one cycle after the rise, with wr_addr=0.
REQ-035 SHALL cover decimation: DECIM=2, 4 valid pulses -> wrt_smpl only on the 2nd and 4th pulses, with wr_addr 0 then 1.
REQ-036 SHALL cover fill and wrap: DEPTH=8, TAPS=5, DECIM=1, 8 writes -> AMP_ON=1, 5 sequencing cycles with rd_addr 0,1,2,3,4; the 9th write has wr_addr=0 and rd_addr 1..5; the 12th write gives rd_addr 4,5,6,7,0.
REQ-037 SHALL cover overrun: with SEQ_OVERRUN_EN, a write in burst cycle 2 -> overrun=1, the burst stays 5 cycles, and no second burst follows.
REQ-038 SHALL cover reset mid-operation: rst in burst cycle 3 -> sequencing=0 next cycle, AMP_ON=0, and the next write after release has wr_addr=0.

Source files
------------

// File: rtl/queue_seq_ctrl.sv
// queue_seq_ctrl: write/read address sequencer for a circular sample queue
// feeding a FIR engine. Each qualified rising edge of the codec strobe
// produces a one-cycle queue write. Once the queue is full, every write
// launches a TAPS-cycle read burst that starts at the oldest sample.
// Optional feature: define SEQ_OVERRUN_EN to add the sticky 'overrun' output,
// which flags a write landing while a read burst is in progress.
module queue_seq_ctrl #(
    parameter int DEPTH = 1024,
    parameter int TAPS = 1021,
    parameter int DECIM = 2,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    output logic              wrt_smpl,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              sequencing,
    output logic              AMP_ON
`ifdef SEQ_OVERRUN_EN
    ,
    output logic              overrun
`endif
);

    localparam int TAP_W = $clog2(TAPS + 1);
    localparam logic [ADDR_W:0] FILL_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);

    // Reject configurations the address arithmetic cannot support
    generate
        if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("queue_seq_ctrl: DEPTH must be a power of 2 and at least 4");
        end
        if (TAPS < 1 || TAPS >= DEPTH) begin : g_bad_taps
            $error("queue_seq_ctrl: TAPS must satisfy 1 <= TAPS < DEPTH");
        end
        if (DECIM != 1 && DECIM != 2) begin : g_bad_decim
            $error("queue_seq_ctrl: DECIM must be 1 or 2");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic              valid_d;
    logic              phase;
    logic              edge_det;
    logic              qual_edge;
    logic [ADDR_W-1:0] new_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   fill_cnt;
    logic [TAP_W-1:0]  tap_cnt;
    logic              queue_full;
    logic              start_burst;

    assign edge_det    = valid & ~valid_d;
    assign qual_edge   = (DECIM == 1) ? edge_det : (edge_det & phase);
    assign queue_full  = (fill_cnt == FILL_MAX);
    assign start_burst = wrt_smpl & queue_full & (state == IDLE);

    // Edge detection, decimation phase and the queue write side
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_d  <= 1'b1;
            phase    <= 1'b0;
            wrt_smpl <= 1'b0;
            wr_addr  <= '0;
            new_ptr  <= '0;
            fill_cnt <= '0;
        end else begin
            valid_d  <= valid;
            wrt_smpl <= qual_edge;
            if (edge_det) begin
                phase <= ~phase;
            end
            if (qual_edge) begin
                wr_addr <= new_ptr;
                new_ptr <= new_ptr + 1'b1;
                if (!queue_full) begin
                    fill_cnt <= fill_cnt + 1'b1;
                end
            end
        end
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a write into a full queue launches a burst of TAPS reads
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_burst) state_next = SEQ;
            SEQ:  if (tap_cnt == LAST_TAP) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Read pointer and tap counter for the burst in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            tap_cnt <= '0;
        end else if (start_burst) begin
            rd_ptr  <= new_ptr;
            tap_cnt <= '0;
        end else if (state == SEQ) begin
            rd_ptr  <= rd_ptr + 1'b1;
            tap_cnt <= tap_cnt + 1'b1;
        end
    end

    // Sticky fill indication, set the cycle after the queue becomes full
    always_ff @(posedge clk) begin
        if (rst) begin
            AMP_ON <= 1'b0;
        end else begin
            AMP_ON <= AMP_ON | queue_full;
        end
    end

`ifdef SEQ_OVERRUN_EN
    // Sticky flag for a write that lands while a burst is reading the queue
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else begin
            overrun <= overrun | (wrt_smpl & (state == SEQ));
        end
    end
`endif

    // Read-side outputs, parked at zero outside a burst
    always_comb begin
        sequencing = 1'b0;
        rd_addr    = '0;
        if (state == SEQ) begin
            sequencing = 1'b1;
            rd_addr    = rd_ptr;
        end
    end

endmodule

// File: tb/tb_queue_seq_ctrl.sv
// tb_queue_seq_ctrl: two instances (DECIM=1 and DECIM=2, DEPTH=8, TAPS=5)
// share clock, reset and strobe. A count-based reference model predicts
// every output each cycle; a vector table and directed sequences cover the
// reset, strobing, decimation, wrap, overrun and mid-burst reset cases.
// Define SEQ_OVERRUN_EN to also exercise the overrun output.
module tb_queue_seq_ctrl;

    localparam int DEP = 8;
    localparam int TP = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic valid = 1'b0;

    logic       w1, w2, sq1, sq2, amp1, amp2;
    logic [2:0] wa1, wa2, rd1, rd2;
`ifdef SEQ_OVERRUN_EN
    logic       ov1, ov2;
`endif

    int tests = 0;
    int failed = 0;

    // reference model state, index 0 = DECIM 1, index 1 = DECIM 2
    int m_prev_v[2];
    int m_edges[2];
    int m_nwr[2];
    int m_left[2];
    int e_wrt[2];
    int e_wra[2];
    int e_seq[2];
    int e_rd[2];
    int e_amp[2];
`ifdef SEQ_OVERRUN_EN
    int e_ovr[2];
`endif

    int wq1[$];
    int wq2[$];
    int rq1[$];

    typedef struct {
        logic r;
        logic v;
        logic e_wrt;
        logic [2:0] e_wra;
        logic e_seq;
        logic e_amp;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    queue_seq_ctrl #(.DEPTH(DEP), .TAPS(TP), .DECIM(1)) dut1 (
        .clk(clk), .rst(rst), .valid(valid),
        .wrt_smpl(w1), .wr_addr(wa1), .rd_addr(rd1),
        .sequencing(sq1), .AMP_ON(amp1)
`ifdef SEQ_OVERRUN_EN
        , .overrun(ov1)
`endif
    );

    queue_seq_ctrl #(.DEPTH(DEP), .TAPS(TP), .DECIM(2)) dut2 (
        .clk(clk), .rst(rst), .valid(valid),
        .wrt_smpl(w2), .wr_addr(wa2), .rd_addr(rd2),
        .sequencing(sq2), .AMP_ON(amp2)
`ifdef SEQ_OVERRUN_EN
        , .overrun(ov2)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs seen at that edge
    task automatic modelStep(input int d, input logic r, input logic v);
        int was_wrt;
        int was_seq;
        if (r) begin
            m_prev_v[d] = 1; m_edges[d] = 0; m_nwr[d] = 0; m_left[d] = 0;
            e_wrt[d] = 0; e_wra[d] = 0; e_seq[d] = 0; e_rd[d] = 0; e_amp[d] = 0;
`ifdef SEQ_OVERRUN_EN
            e_ovr[d] = 0;
`endif
            return;
        end
        was_wrt = e_wrt[d];
        was_seq = e_seq[d];
        if (was_wrt != 0 && m_nwr[d] >= DEP) e_amp[d] = 1;
`ifdef SEQ_OVERRUN_EN
        if (was_wrt != 0 && was_seq != 0) e_ovr[d] = 1;
`endif
        if (was_seq != 0) begin
            m_left[d]--;
            if (m_left[d] == 0) begin
                e_seq[d] = 0;
                e_rd[d] = 0;
            end else begin
                e_rd[d] = (e_rd[d] + 1) % DEP;
            end
        end
        if (was_wrt != 0 && was_seq == 0 && m_nwr[d] >= DEP) begin
            e_seq[d] = 1;
            e_rd[d] = m_nwr[d] % DEP;
            m_left[d] = TP;
        end
        e_wrt[d] = 0;
        if (v == 1'b1 && m_prev_v[d] == 0) begin
            if (d == 0 || (m_edges[d] % 2) == 1) begin
                e_wrt[d] = 1;
                e_wra[d] = m_nwr[d] % DEP;
                m_nwr[d]++;
            end
            m_edges[d]++;
        end
        m_prev_v[d] = (v == 1'b1) ? 1 : 0;
    endtask

    // Drive one cycle of inputs, clock it, then compare both instances to the model
    task automatic applyStimulus(input logic r, input logic v);
        rst = r;
        valid = v;
        @(posedge clk);
        modelStep(0, r, v);
        modelStep(1, r, v);
        #1;
        checkOutput("d1 wrt_smpl", 32'(w1), e_wrt[0]);
        checkOutput("d1 wr_addr", 32'(wa1), e_wra[0]);
        checkOutput("d1 sequencing", 32'(sq1), e_seq[0]);
        checkOutput("d1 rd_addr", 32'(rd1), e_rd[0]);
        checkOutput("d1 AMP_ON", 32'(amp1), e_amp[0]);
        checkOutput("d2 wrt_smpl", 32'(w2), e_wrt[1]);
        checkOutput("d2 wr_addr", 32'(wa2), e_wra[1]);
        checkOutput("d2 sequencing", 32'(sq2), e_seq[1]);
        checkOutput("d2 rd_addr", 32'(rd2), e_rd[1]);
        checkOutput("d2 AMP_ON", 32'(amp2), e_amp[1]);
`ifdef SEQ_OVERRUN_EN
        checkOutput("d1 overrun", 32'(ov1), e_ovr[0]);
        checkOutput("d2 overrun", 32'(ov2), e_ovr[1]);
`endif
        if (w1) wq1.push_back(int'(wa1));
        if (w2) wq2.push_back(int'(wa2));
        if (sq1) rq1.push_back(int'(rd1));
    endtask

    task automatic pulse(input int gap);
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < gap; i++) applyStimulus(1'b0, 1'b0);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
    endtask

    task automatic checkBurst(input string name, input int base);
        checkOutput({name, " length"}, rq1.size(), TP);
        for (int i = 0; i < rq1.size() && i < TP; i++)
            checkOutput({name, " rd_addr"}, rq1[i], (base + i) % DEP);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pos;
        int found;
        int seq_cnt;

        // reset with valid high, release with valid high, then one long rise
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].r, vecs[i].v);
            checkOutput("vec wrt_smpl", 32'(w1), 32'(vecs[i].e_wrt));
            checkOutput("vec wr_addr", 32'(wa1), 32'(vecs[i].e_wra));
            checkOutput("vec sequencing", 32'(sq1), 32'(vecs[i].e_seq));
            checkOutput("vec AMP_ON", 32'(amp1), 32'(vecs[i].e_amp));
        end

        // decimation: four pulses give writes 0 and 1 on the DECIM=2 instance
        doReset();
        wq1.delete(); wq2.delete();
        for (int i = 0; i < 4; i++) pulse(3);
        checkOutput("decim d2 write count", wq2.size(), 2);
        if (wq2.size() == 2) begin
            checkOutput("decim d2 first addr", wq2[0], 0);
            checkOutput("decim d2 second addr", wq2[1], 1);
        end
        checkOutput("decim d1 write count", wq1.size(), 4);

        // fill and wrap
        doReset();
        for (int i = 0; i < 7; i++) pulse(8);
        checkOutput("fill AMP_ON before full", 32'(amp1), 0);
        rq1.delete(); wq1.delete();
        pulse(8);
        checkOutput("fill AMP_ON", 32'(amp1), 1);
        checkBurst("fill burst8", 0);
        rq1.delete(); wq1.delete();
        pulse(8);
        checkOutput("wrap write9 count", wq1.size(), 1);
        if (wq1.size() == 1) checkOutput("wrap write9 addr", wq1[0], 0);
        checkBurst("wrap burst9", 1);
        pulse(8);
        pulse(8);
        rq1.delete(); wq1.delete();
        pulse(8);
        if (wq1.size() == 1) checkOutput("wrap write12 addr", wq1[0], 3);
        checkBurst("wrap burst12", 4);

        // reset in burst cycle 3
        applyStimulus(1'b0, 1'b1);
        pos = 0;
        found = 0;
        for (int i = 0; i < 12 && found == 0; i++) begin
            applyStimulus(1'b0, 1'b0);
            if (sq1) begin
                pos++;
                if (pos == 3) found = 1;
            end
        end
        checkOutput("midrst reached burst cycle 3", found, 1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("midrst sequencing", 32'(sq1), 0);
        checkOutput("midrst AMP_ON", 32'(amp1), 0);
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0);
        checkOutput("midrst no burst resumes", 32'(sq1), 0);
        wq1.delete();
        pulse(8);
        checkOutput("midrst next write count", wq1.size(), 1);
        if (wq1.size() == 1) checkOutput("midrst next write addr", wq1[0], 0);

        // write landing in burst cycle 2: burst stays TAPS long, no second burst
        doReset();
        for (int i = 0; i < 8; i++) pulse(8);
        rq1.delete(); wq1.delete();
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        seq_cnt = 0;
        for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b0);
        seq_cnt = rq1.size();
        checkOutput("overlap burst length", seq_cnt, TP);
        checkOutput("overlap write count", wq1.size(), 2);
`ifdef SEQ_OVERRUN_EN
        checkOutput("overlap overrun", 32'(ov1), 1);
`endif

        // randomized traffic with occasional resets
        doReset();
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
